mux_nway_arb: RTL and testbench

MUX_NWAY_ARB -- requirements
Module: mux_nway_arb

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mux_nway_arb.sv | 93 +++++++++
 tb/tb_mux_nway_arb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-way arbitrating mux.
// Mode encodings and a constant-foldable clog2 used for select widths.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick: first requester at or after ptr, wrapping at WAYS.
// Zero latency, no backpressure; ptr is assumed to be below WAYS.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SELW = clog2(WAYS)
) (
  input  logic [WAYS-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_vld
);

  int              w_idx;
  logic [WAYS-1:0] w_req_sh;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    w_idx     = 0;
    w_req_sh  = '0;
    for (int k = 0; k < WAYS; k++) begin
      // Explicit modulo so a non-power-of-two WAYS wraps to 0, not to 2**SELW.
      w_idx = int'(ptr) + k;
      if (w_idx >= WAYS) w_idx = w_idx - WAYS;
      w_req_sh = req >> w_idx;
      if (!grant_vld && w_req_sh[0]) begin
        grant     = SELW'(w_idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nway_arb.sv
// N-way mux with explicit-select or round-robin grant into a one-entry output register (1-cycle latency).
// Backpressure: in_ready is zero whenever the held word is not being drained; drain and reload share a cycle.
module mux_nway_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WAYS  = 4,
  parameter int SELW  = clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_src
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_src;
  logic [SELW-1:0]  r_ptr;

  logic [SELW-1:0]  w_rr_grant;
  logic             w_rr_vld;
  logic             w_sel_hit;
  logic [SELW-1:0]  w_grant;
  logic             w_gnt_vld;
  logic             w_can_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;
  logic [SELW-1:0]  w_ptr_nxt;

  rr_arbiter #(
    .WAYS (WAYS),
    .SELW (SELW)
  ) u_rr (
    .req       (in_valid),
    .ptr       (r_ptr),
    .grant     (w_rr_grant),
    .grant_vld (w_rr_vld)
  );

  // A sel value at or above WAYS never matches a loop index, so it yields no grant.
  always_comb begin
    w_sel_hit = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (sel == SELW'(i)) w_sel_hit = in_valid[i];
    end
  end

  assign w_grant      = (mode == MODE_RR) ? w_rr_grant : sel;
  assign w_gnt_vld    = (mode == MODE_RR) ? w_rr_vld : w_sel_hit;
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_xfer       = w_gnt_vld && w_can_accept && !reset;
  assign w_ptr_nxt    = (w_grant == SELW'(WAYS - 1)) ? '0 : w_grant + SELW'(1);

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (w_grant == SELW'(i)) begin
        in_ready[i] = w_xfer;
        w_gnt_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_src   <= w_grant;
      if (mode == MODE_RR) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Bench for mux_nway_arb: directed scenarios plus random traffic against a queue-free reference model,
// driving a 4-way and a 3-way instance from the same stimulus and checking whichever is selected.
module tb_mux_nway_arb;

  localparam int W = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] t_data;
  logic [3:0]  t_valid;
  logic [1:0]  sel;
  logic        mode;
  logic        out_ready;

  logic [3:0]  rdy4;
  logic [15:0] od4;
  logic        ov4;
  logic [1:0]  os4;
  logic [2:0]  rdy3;
  logic [15:0] od3;
  logic        ov3;
  logic [1:0]  os3;

  mux_nway_arb #(.WIDTH(W), .WAYS(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(t_data), .in_valid(t_valid), .in_ready(rdy4),
    .sel(sel), .mode(mode), .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .out_src(os4)
  );

  mux_nway_arb #(.WIDTH(W), .WAYS(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(t_data[47:0]), .in_valid(t_valid[2:0]), .in_ready(rdy3),
    .sel(sel), .mode(mode), .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .out_src(os3)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = 0;

  // Reference model state: the output register contents and the round-robin pointer.
  bit          m_valid;
  logic [15:0] m_data;
  int          m_src;
  int          m_ptr;

  function automatic logic [3:0] obs_rdy();
    return (cur != 0) ? {1'b0, rdy3} : rdy4;
  endfunction
  function automatic logic [15:0] obs_data();
    return (cur != 0) ? od3 : od4;
  endfunction
  function automatic logic obs_valid();
    return (cur != 0) ? ov3 : ov4;
  endfunction
  function automatic logic [1:0] obs_src();
    return (cur != 0) ? os3 : os4;
  endfunction
  function automatic logic [1:0] obs_ptr();
    return (cur != 0) ? dut3.r_ptr : dut4.r_ptr;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  // One clock: check combinational in_ready, take the edge, then check registered state.
  task automatic step();
    int         ways;
    bit         gv;
    int         g;
    int         idx;
    bit         can;
    logic [3:0] exp_rdy;
    ways = (cur != 0) ? 3 : 4;
    gv   = 1'b0;
    g    = 0;
    #1;
    if (mode == 1'b0) begin
      g  = int'(sel);
      gv = (g < ways) && t_valid[g];
    end else begin
      for (int k = 0; k < ways; k++) begin
        idx = (m_ptr + k) % ways;
        if (!gv && t_valid[idx]) begin
          gv = 1'b1;
          g  = idx;
        end
      end
    end
    can     = !m_valid || out_ready;
    exp_rdy = (!reset && gv && can) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 64'(obs_rdy()), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else if (gv && can) begin
      m_valid = 1'b1;
      m_data  = t_data[g*W +: W];
      m_src   = g;
      if (mode == 1'b1) m_ptr = (g + 1) % ways;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    chk("out_valid", 64'(obs_valid()), 64'(m_valid));
    chk("out_data",  64'(obs_data()),  64'(m_data));
    chk("out_src",   64'(obs_src()),   64'(m_src));
    chk("ptr",       64'(obs_ptr()),   64'(m_ptr));
  endtask

  initial begin
    int exp_src[6];
    logic [15:0] held;
    reset     = 1'b1;
    t_data    = '0;
    t_valid   = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset then idle.
    @(posedge clk);
    #1;
    step();
    chk("rst_in_ready", 64'(obs_rdy()), 64'h0);
    step();
    chk("rst_out_valid", 64'(obs_valid()), 64'h0);
    chk("rst_out_src", 64'(obs_src()), 64'h0);
    reset = 1'b0;
    step();
    chk("idle_in_ready", 64'(obs_rdy()), 64'h0);

    // Explicit select of way 2, streaming.
    mode      = 1'b0;
    sel       = 2'd2;
    t_valid   = 4'b1111;
    t_data    = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sel2_data", 64'(obs_data()), 64'h000C);
      chk("sel2_src", 64'(obs_src()), 64'd2);
      chk("sel2_ptr", 64'(obs_ptr()), 64'd0);
    end

    // Round-robin over ways 0, 1, 3.
    mode    = 1'b1;
    t_valid = 4'b1011;
    exp_src = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_onehot", 64'($onehot(obs_rdy())), 64'd1);
      step();
      chk("rr_src_seq", 64'(obs_src()), 64'(exp_src[i]));
    end

    // Backpressure for three cycles after a transfer.
    t_valid = 4'b1111;
    step();
    chk("bp_first_src", 64'(obs_src()), 64'd0);
    held      = obs_data();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_held_data", 64'(obs_data()), 64'(held));
      chk("bp_ptr_hold", 64'(obs_ptr()), 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_src", 64'(obs_src()), 64'd1);
    chk("bp_release_data", 64'(obs_data()), 64'h000B);

    // Reset while a word is held under backpressure.
    out_ready = 1'b0;
    step();
    chk("mid_held_valid", 64'(obs_valid()), 64'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 64'(obs_valid()), 64'd0);
    chk("mid_rst_ptr", 64'(obs_ptr()), 64'd0);
    reset     = 1'b0;
    t_valid   = 4'b0110;
    out_ready = 1'b1;
    step();
    chk("mid_rst_lowest", 64'(obs_src()), 64'd1);

    // Three-way instance: non-power-of-two wrap.
    cur   = 1;
    reset = 1'b1;
    step();
    reset   = 1'b0;
    t_valid = 4'b0111;
    exp_src = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("w3_src_seq", 64'(obs_src()), 64'(exp_src[i]));
      chk("w3_ptr_lt3", 64'(obs_ptr() < 2'd3), 64'd1);
    end

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      cur   = d;
      reset = 1'b1;
      step();
      for (int i = 0; i < 300; i++) begin
        reset     = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
        sel       = 2'($urandom_range(0, 3));
        t_valid   = 4'($urandom);
        t_data    = {$urandom, $urandom};
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
